// File: rtl/hazard_scoreboard.sv
// Purpose: pipeline hazard unit with load-use/branch stalls, D/E forwarding and a one-entry MD scoreboard.
// Latency: hazards/forwards are combinational; an MD op holds md_busy for MD_LAT cycles after the accepting edge.
// Backpressure: decode stalls on load-use, branch or pending-MD dependency; HAZ_PERF_EN adds saturating stall counters.
module hazard_scoreboard #(
    parameter int RW     = 5,
    parameter int MD_LAT = 32,
    parameter int CNTW   = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          branchD,
    input  logic          memtoregE,
    input  logic          regwriteE,
    input  logic          memtoregM,
    input  logic          regwriteM,
    input  logic          regwriteW,
    input  logic          md_startD,
    input  logic          md_startE,
    input  logic [RW-1:0] md_wregE,
    input  logic [RW-1:0] rsD,
    input  logic [RW-1:0] rtD,
    input  logic [RW-1:0] rsE,
    input  logic [RW-1:0] rtE,
    input  logic [RW-1:0] writeregE,
    input  logic [RW-1:0] writeregM,
    input  logic [RW-1:0] writeregW,
    output logic          stallF,
    output logic          stallD,
    output logic          flushE,
    output logic          forwardaD,
    output logic          forwardbD,
    output logic [1:0]    forwardaE,
    output logic [1:0]    forwardbE,
    output logic          md_busy,
    output logic          md_done,
    output logic          md_err,
    output logic [31:0]   perf_stall,
    output logic [31:0]   perf_mdstall
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mdState_t;

    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(MD_LAT - 1);

    mdState_t        state, stateNext;
    logic [CNTW-1:0] cnt, cntNext;
    logic [RW-1:0]   pendReg, pendNext;
    logic            errQ, errNext;

    logic lwStall, bsc1, bsc2, branchStall, mdStall, pendHit;

    // Load-use and branch-compare hazards; register 0 never matches.
    assign lwStall     = memtoregE && (rtE != '0) && ((rtE == rsD) || (rtE == rtD));
    assign bsc1        = regwriteE && (writeregE != '0) && ((writeregE == rsD) || (writeregE == rtD));
    assign bsc2        = memtoregM && (writeregM != '0) && ((writeregM == rsD) || (writeregM == rtD));
    assign branchStall = branchD && (bsc1 || bsc2);

    assign forwardaD = (rsD != '0) && (rsD == writeregM) && regwriteM;
    assign forwardbD = (rtD != '0) && (rtD == writeregM) && regwriteM;

    // Execute-stage forwarding: memory stage wins over writeback.
    always_comb begin
        forwardaE = 2'b00;
        forwardbE = 2'b00;
        if ((rsE != '0) && (rsE == writeregM) && regwriteM)      forwardaE = 2'b10;
        else if ((rsE != '0) && (rsE == writeregW) && regwriteW) forwardaE = 2'b01;
        if ((rtE != '0) && (rtE == writeregM) && regwriteM)      forwardbE = 2'b10;
        else if ((rtE != '0) && (rtE == writeregW) && regwriteW) forwardbE = 2'b01;
    end

    assign md_busy = (state == BUSY);
    assign md_done = md_busy && (cnt == '0);
    assign md_err  = errQ;

    // The write-first register file makes the md_done cycle safe, so only earlier busy cycles stall.
    assign pendHit = (pendReg != '0) && ((rsD == pendReg) || (rtD == pendReg));
    assign mdStall = md_busy && !md_done && (pendHit || md_startD);

    assign flushE = lwStall || branchStall || mdStall;
    assign stallD = flushE;
    assign stallF = flushE;

    // MD sequencer next-state: accept in IDLE or in the done cycle, flag issues while still counting.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        pendNext  = pendReg;
        errNext   = errQ;
        case (state)
            IDLE: begin
                if (md_startE) begin
                    stateNext = BUSY;
                    cntNext   = CNT_LOAD;
                    pendNext  = md_wregE;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    if (md_startE) begin
                        cntNext  = CNT_LOAD;
                        pendNext = md_wregE;
                    end else begin
                        stateNext = IDLE;
                        pendNext  = '0;
                    end
                end else begin
                    cntNext = cnt - CNTW'(1);
                    if (md_startE) errNext = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // MD sequencer state; reset aborts any op in flight without a done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pendReg <= '0;
            errQ    <= 1'b0;
        end else begin
            state   <= stateNext;
            cnt     <= cntNext;
            pendReg <= pendNext;
            errQ    <= errNext;
        end
    end

`ifdef HAZ_PERF_EN
    logic [31:0] perfStallQ, perfMdStallQ;

    // Saturating stall-cycle counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perfStallQ   <= '0;
            perfMdStallQ <= '0;
        end else begin
            if (flushE && (perfStallQ != '1))    perfStallQ   <= perfStallQ + 32'd1;
            if (mdStall && (perfMdStallQ != '1)) perfMdStallQ <= perfMdStallQ + 32'd1;
        end
    end

    assign perf_stall   = perfStallQ;
    assign perf_mdstall = perfMdStallQ;
`else
    assign perf_stall   = '0;
    assign perf_mdstall = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Purpose: directed self-checking bench for hazard_scoreboard with MD_LAT=4.
// Latency: inputs change 2 time units after a rising edge, outputs sampled 1 unit later.
// Backpressure: not applicable; the bench drives stall inputs directly.
module tb_hazard_scoreboard;

    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          branchD, memtoregE, regwriteE, memtoregM, regwriteM, regwriteW;
    logic          md_startD, md_startE;
    logic [RW-1:0] md_wregE, rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic          stallF, stallD, flushE, forwardaD, forwardbD;
    logic [1:0]    forwardaE, forwardbE;
    logic          md_busy, md_done, md_err;
    logic [31:0]   perf_stall, perf_mdstall;

    int testsRun  = 0;
    int testsFail = 0;

    hazard_scoreboard #(.RW(RW), .MD_LAT(4), .CNTW(8)) dut (
        .clk(clk), .reset(reset), .branchD(branchD),
        .memtoregE(memtoregE), .regwriteE(regwriteE),
        .memtoregM(memtoregM), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .md_startD(md_startD), .md_startE(md_startE), .md_wregE(md_wregE),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .stallF(stallF), .stallD(stallD), .flushE(flushE),
        .forwardaD(forwardaD), .forwardbD(forwardbD),
        .forwardaE(forwardaE), .forwardbE(forwardbE),
        .md_busy(md_busy), .md_done(md_done), .md_err(md_err),
        .perf_stall(perf_stall), .perf_mdstall(perf_mdstall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clearInputs();
        branchD = 0; memtoregE = 0; regwriteE = 0; memtoregM = 0; regwriteM = 0; regwriteW = 0;
        md_startD = 0; md_startE = 0; md_wregE = '0;
        rsD = '0; rtD = '0; rsE = '0; rtE = '0;
        writeregE = '0; writeregM = '0; writeregW = '0;
    endtask

    task automatic stallTriple(input string tag, input logic exp);
        #1;
        chk({tag, "_flushE"}, 32'(flushE), 32'(exp));
        chk({tag, "_stallD"}, 32'(stallD), 32'(exp));
        chk({tag, "_stallF"}, 32'(stallF), 32'(exp));
    endtask

    initial begin
        clearInputs();
        reset = 1'b0;
        #1;
        chk("rst_busy", 32'(md_busy), 0);
        chk("rst_done", 32'(md_done), 0);
        chk("rst_err", 32'(md_err), 0);
        chk("rst_flush", 32'(flushE), 0);
        chk("rst_perf", perf_stall, 0);
        #2 reset = 1'b1;

        // Basic MD op, wreg=9, dependent and independent decode reads.
        tick();
        md_startE = 1; md_wregE = 5'd9;
        tick();                       // edge 0 accepted
        md_startE = 0; rsD = 5'd9;
        for (int c = 1; c <= 3; c++) begin
            stallTriple($sformatf("dep_c%0d", c), 1'b1);
            chk($sformatf("busy_c%0d", c), 32'(md_busy), 1);
            chk($sformatf("done_c%0d", c), 32'(md_done), 0);
            if (c == 2) begin
                rsD = 5'd10;
                #1 chk("indep_c2", 32'(flushE), 0);
                rsD = 5'd9;
            end
            tick();
        end
        stallTriple("dep_c4", 1'b0);
        chk("busy_c4", 32'(md_busy), 1);
        chk("done_c4", 32'(md_done), 1);
        tick();
        #1;
        chk("busy_c5", 32'(md_busy), 0);
        chk("done_c5", 32'(md_done), 0);
        chk("flush_c5", 32'(flushE), 0);

        // Second MD op in decode stalls; back-to-back issue in done cycle; illegal issue sets md_err.
        rsD = '0;
        md_startE = 1; md_wregE = 5'd9;
        tick();
        md_startE = 0; md_startD = 1;
        for (int c = 1; c <= 3; c++) begin
            #1 chk($sformatf("mdD_c%0d", c), 32'(flushE), 1);
            tick();
        end
        #1 chk("mdD_c4", 32'(flushE), 0);
        chk("mdD_done_c4", 32'(md_done), 1);
        md_startD = 0; md_startE = 1; md_wregE = 5'd3;
        tick();                       // reload edge
        md_startE = 0;
        #1;
        chk("b2b_busy", 32'(md_busy), 1);
        chk("b2b_done", 32'(md_done), 0);
        chk("b2b_err", 32'(md_err), 0);
        tick();                       // cycle 2 of new op
        md_startE = 1; md_wregE = 5'd7;
        tick();                       // cycle 3
        md_startE = 0; rtD = 5'd3;
        #1;
        chk("err_set", 32'(md_err), 1);
        chk("pend3_stall", 32'(flushE), 1);
        rtD = 5'd7;
        #1 chk("ignored_wreg", 32'(flushE), 0);
        rtD = '0;
        tick();                       // cycle 4
        #1 chk("err_done_c4", 32'(md_done), 1);
        tick();
        #1;
        chk("err_idle", 32'(md_busy), 0);
        chk("err_sticky", 32'(md_err), 1);

        // Reset in the middle of an op.
        md_startE = 1; md_wregE = 5'd9;
        tick();
        md_startE = 0;
        tick();                       // cycle 2
        reset = 1'b0;
        #1;
        chk("abort_busy", 32'(md_busy), 0);
        chk("abort_err", 32'(md_err), 0);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            #1 chk($sformatf("abort_nodone_%0d", c), 32'({md_busy, md_done}), 0);
        end

        // Load-use stall and r0 exclusion.
        memtoregE = 1; rtE = 5'd5; rtD = 5'd5;
        stallTriple("lw", 1'b1);
        rtE = '0; rtD = '0;
        #1 chk("lw_r0", 32'(flushE), 0);
        memtoregE = 0;

        // Branch stalls from E write and M load.
        branchD = 1; regwriteE = 1; writeregE = 5'd4; rsD = 5'd4;
        #1 chk("bsc1", 32'(flushE), 1);
        writeregE = '0; rsD = '0;
        #1 chk("bsc1_r0", 32'(flushE), 0);
        regwriteE = 0; memtoregM = 1; writeregM = 5'd6; rtD = 5'd6;
        #1 chk("bsc2", 32'(flushE), 1);
        branchD = 0;
        #1 chk("bsc2_nobranch", 32'(flushE), 0);
        memtoregM = 0;

        // Decode forwarding from M.
        regwriteM = 1; rsD = 5'd6;
        #1 chk("fwdD", 32'({forwardaD, forwardbD}), 32'b11);
        regwriteM = 0;
        #1 chk("fwdD_nowr", 32'({forwardaD, forwardbD}), 0);
        rsD = '0; rtD = '0;

        // Execute forwarding priority.
        rsE = 5'd7; writeregM = 5'd7; regwriteM = 1; writeregW = 5'd7; regwriteW = 1;
        #1 chk("fwdaE_M", 32'(forwardaE), 32'b10);
        regwriteM = 0;
        #1 chk("fwdaE_W", 32'(forwardaE), 32'b01);
        rsE = '0; writeregM = '0; writeregW = '0;
        #1 chk("fwdaE_r0", 32'(forwardaE), 32'b00);
        rtE = 5'd12; writeregW = 5'd12;
        #1 chk("fwdbE_W", 32'(forwardbE), 32'b01);
        clearInputs();

`ifdef HAZ_PERF_EN
        reset = 1'b0;
        #1 reset = 1'b1;
        tick();
        memtoregE = 1; rtE = 5'd5; rsD = 5'd5;
        tick(); tick(); tick();
        clearInputs();
        #1;
        chk("perf_stall3", perf_stall, 32'd3);
        chk("perf_md0", perf_mdstall, 32'd0);
        md_startE = 1; md_wregE = 5'd8;
        tick();
        md_startE = 0; rsD = 5'd8;
        tick(); tick();
        clearInputs();
        #1;
        chk("perf_md2", perf_mdstall, 32'd2);
        chk("perf_stall5", perf_stall, 32'd5);
        reset = 1'b0;
        #1 chk("perf_clr", perf_stall, 32'd0);
        reset = 1'b1;
`else
        #1 chk("perf_off", perf_stall | perf_mdstall, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule
